// File: rtl/store_buffer.sv
// In-order store buffer between the memory stage and the data cache.
// Forwards buffered stores to younger loads and drains through a valid/ready port.
module store_buffer #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         StoreValidM,
    input  logic [ADDR_W-1:0]            StoreAddrM,
    input  logic [WORD_SIZE-1:0]         StoreDataM,
    input  logic                         StoreByteM,
    input  logic                         LoadValidM,
    input  logic [ADDR_W-1:0]            LoadAddrM,
    input  logic                         LoadByteM,
    input  logic                         Flush,
    output logic                         LoadHitM,
    output logic [WORD_SIZE-1:0]         LoadDataM,
    output logic                         SBStall,
    output logic                         DrainValid,
    output logic [ADDR_W-1:0]            DrainAddr,
    output logic [WORD_SIZE-1:0]         DrainData,
    output logic                         DrainByte,
    input  logic                         DrainReady,
    output logic                         Empty,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    e_addr [DEPTH];
    logic [WORD_SIZE-1:0] e_data [DEPTH];
    logic                 e_byte [DEPTH];
    logic [DEPTH-1:0]     e_valid;
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 flush_pend;
    logic                 flush_next;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 fwd_hit;
    logic                 fwd_conflict;
    logic [WORD_SIZE-1:0] fwd_data;

    assign full       = (count == CW'(DEPTH));
    assign push       = StoreValidM && !full;
    assign pop        = (state == DRAIN) && DrainReady;
    assign DrainValid = (state == DRAIN);
    assign DrainAddr  = e_addr[head];
    assign DrainData  = e_data[head];
    assign DrainByte  = e_byte[head];
    assign Empty      = (count == '0);
    assign Count      = count;
    assign SBStall    = (StoreValidM && full) || fwd_conflict;
    assign LoadHitM   = fwd_hit && !fwd_conflict;
    assign LoadDataM  = LoadHitM ? fwd_data : '0;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Fence request stays armed until the last entry leaves.
    always_comb begin
        flush_next = flush_pend;
        if (Flush && !Empty) begin
            flush_next = 1'b1;
        end
        if (pop && count_next == '0) begin
            flush_next = 1'b0;
        end
    end

    // Walk oldest to youngest so the youngest overlapping entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        logic [7:0]    lane;
        logic          ovl;
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_data     = '0;
        idx          = '0;
        lane         = '0;
        ovl          = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = head + PW'(i);
            lane = 8'(e_data[idx] >> {LoadAddrM[1:0], 3'b000});
            ovl  = e_valid[idx]
                && (e_addr[idx][ADDR_W-1:2] == LoadAddrM[ADDR_W-1:2])
                && (!e_byte[idx]
                    || (e_addr[idx][1:0] == LoadAddrM[1:0])
                    || !LoadByteM);
            if (LoadValidM && ovl) begin
                fwd_hit = 1'b1;
                if (!LoadByteM && e_byte[idx]) begin
                    fwd_conflict = 1'b1;
                end
                if (e_byte[idx]) begin
                    fwd_data = {{(WORD_SIZE-8){1'b0}}, e_data[idx][7:0]};
                end else if (LoadByteM) begin
                    fwd_data = {{(WORD_SIZE-8){1'b0}}, lane};
                end else begin
                    fwd_data = e_data[idx];
                end
            end
        end
    end

    // Drain FSM next state: hold the head until the cache takes it.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!Empty && (!LoadValidM || full || flush_pend)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop) begin
                    if (count_next != '0
                        && (!LoadValidM
                            || count_next == CW'(DEPTH)
                            || flush_next)) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointers, occupancy, valid bits and fence flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            e_valid    <= '0;
            flush_pend <= 1'b0;
        end else begin
            count      <= count_next;
            flush_pend <= flush_next;
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                e_valid[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
        end
    end

    // Entry payload; no reset needed since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            e_addr[tail] <= StoreAddrM;
            e_data[tail] <= StoreDataM;
            e_byte[tail] <= StoreByteM;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StoreValidM;
    logic [31:0] StoreAddrM;
    logic [31:0] StoreDataM;
    logic        StoreByteM;
    logic        LoadValidM;
    logic [31:0] LoadAddrM;
    logic        LoadByteM;
    logic        Flush;
    logic        LoadHitM;
    logic [31:0] LoadDataM;
    logic        SBStall;
    logic        DrainValid;
    logic [31:0] DrainAddr;
    logic [31:0] DrainData;
    logic        DrainByte;
    logic        DrainReady;
    logic        Empty;
    logic [2:0]  Count;

    int tests = 0;
    int fails = 0;

    store_buffer #(.WORD_SIZE(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .StoreValidM(StoreValidM), .StoreAddrM(StoreAddrM),
        .StoreDataM(StoreDataM), .StoreByteM(StoreByteM),
        .LoadValidM(LoadValidM), .LoadAddrM(LoadAddrM),
        .LoadByteM(LoadByteM), .Flush(Flush),
        .LoadHitM(LoadHitM), .LoadDataM(LoadDataM), .SBStall(SBStall),
        .DrainValid(DrainValid), .DrainAddr(DrainAddr),
        .DrainData(DrainData), .DrainByte(DrainByte),
        .DrainReady(DrainReady), .Empty(Empty), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        StoreValidM = 0; StoreAddrM = 0; StoreDataM = 0; StoreByteM = 0;
        LoadValidM = 0; LoadAddrM = 0; LoadByteM = 0;
        Flush = 0; DrainReady = 0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic b);
        StoreValidM = 1; StoreAddrM = a; StoreDataM = d; StoreByteM = b;
        tick();
        StoreValidM = 0;
    endtask

    task automatic test_reset();
        do_reset();
        LoadValidM = 1; LoadAddrM = 32'h100;
        #1;
        tests++;
        if (Empty !== 1'b1) begin
            fails++; $display("FAIL rst_empty got=%0b exp=1", Empty);
        end
        tests++;
        if (Count !== 3'd0) begin
            fails++; $display("FAIL rst_count got=%0d exp=0", Count);
        end
        tests++;
        if (DrainValid !== 1'b0) begin
            fails++; $display("FAIL rst_dvalid got=%0b exp=0", DrainValid);
        end
        tests++;
        if ({LoadHitM, SBStall} !== 2'b00) begin
            fails++;
            $display("FAIL rst_hit_stall got=%b exp=00", {LoadHitM, SBStall});
        end
        clr();
    endtask

    task automatic test_fwd_word();
        do_reset();
        store(32'h100, 32'hDEADBEEF, 0);
        LoadValidM = 1; LoadAddrM = 32'h100; LoadByteM = 0;
        #1;
        tests++;
        if ({LoadHitM, SBStall} !== 2'b10) begin
            fails++;
            $display("FAIL fw_hit got=%b exp=10", {LoadHitM, SBStall});
        end
        tests++;
        if (LoadDataM !== 32'hDEADBEEF) begin
            fails++; $display("FAIL fw_data got=%h exp=deadbeef", LoadDataM);
        end
        tests++;
        if (Count !== 3'd1) begin
            fails++; $display("FAIL fw_count got=%0d exp=1", Count);
        end
        clr();
    endtask

    task automatic test_fwd_byte();
        bit ok;
        do_reset();
        store(32'h102, 32'h123456AB, 1);
        LoadValidM = 1; LoadAddrM = 32'h102; LoadByteM = 1;
        #1;
        tests++;
        if ({LoadHitM, SBStall, LoadDataM} !== {2'b10, 32'h000000AB}) begin
            fails++;
            $display("FAIL fb_byte got=%b/%h exp=10/000000ab",
                     {LoadHitM, SBStall}, LoadDataM);
        end
        tick();
        LoadAddrM = 32'h100; LoadByteM = 0;
        Flush = 1; DrainReady = 1;
        #1;
        tests++;
        if ({LoadHitM, SBStall} !== 2'b01) begin
            fails++;
            $display("FAIL fb_conflict got=%b exp=01", {LoadHitM, SBStall});
        end
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            Flush = 0;
            #1;
            if (!SBStall) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL fb_release got=stall exp=released");
        end
        tests++;
        if ({Empty, Count} !== {1'b1, 3'd0}) begin
            fails++;
            $display("FAIL fb_empty got=%b/%0d exp=1/0", Empty, Count);
        end
        clr();
    endtask

    task automatic test_youngest();
        do_reset();
        store(32'h200, 32'd1, 0);
        store(32'h200, 32'd2, 0);
        store(32'h300, 32'h11223344, 0);
        LoadValidM = 1; LoadAddrM = 32'h200; LoadByteM = 0;
        #1;
        tests++;
        if ({LoadHitM, LoadDataM} !== {1'b1, 32'd2}) begin
            fails++;
            $display("FAIL yw_data got=%b/%h exp=1/2", LoadHitM, LoadDataM);
        end
        tick();
        LoadAddrM = 32'h301; LoadByteM = 1;
        #1;
        tests++;
        if ({LoadHitM, LoadDataM} !== {1'b1, 32'h33}) begin
            fails++;
            $display("FAIL yw_lane got=%b/%h exp=1/33", LoadHitM, LoadDataM);
        end
        tick();
        LoadAddrM = 32'h500; LoadByteM = 0;
        #1;
        tests++;
        if ({LoadHitM, SBStall, LoadDataM} !== {2'b00, 32'h0}) begin
            fails++;
            $display("FAIL yw_miss got=%b/%h exp=00/0",
                     {LoadHitM, SBStall}, LoadDataM);
        end
        clr();
    endtask

    task automatic test_full();
        logic [31:0] exp_a [4];
        logic [31:0] exp_d [4];
        int k;
        exp_a = '{32'h404, 32'h408, 32'h40C, 32'h500};
        exp_d = '{32'd2, 32'd3, 32'd4, 32'h55};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            store(32'h400 + 32'(4 * i), 32'(i + 1), 0);
        end
        #1;
        tests++;
        if (Count !== 3'd4) begin
            fails++; $display("FAIL full_count got=%0d exp=4", Count);
        end
        StoreValidM = 1; StoreAddrM = 32'h500; StoreDataM = 32'h55;
        #1;
        tests++;
        if (SBStall !== 1'b1) begin
            fails++; $display("FAIL full_stall got=%0b exp=1", SBStall);
        end
        tick();
        DrainReady = 1;
        #1;
        tests++;
        if ({Count, SBStall, DrainAddr} !== {3'd4, 1'b1, 32'h400}) begin
            fails++;
            $display("FAIL full_hold got=%0d/%0b/%h exp=4/1/400",
                     Count, SBStall, DrainAddr);
        end
        tick();
        DrainReady = 0;
        #1;
        tests++;
        if ({Count, SBStall} !== {3'd3, 1'b0}) begin
            fails++;
            $display("FAIL full_pop got=%0d/%0b exp=3/0", Count, SBStall);
        end
        tick();
        StoreValidM = 0;
        #1;
        tests++;
        if (Count !== 3'd4) begin
            fails++; $display("FAIL full_retry got=%0d exp=4", Count);
        end
        DrainReady = 1;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            #1;
            if (DrainValid) begin
                tests++;
                if ({DrainAddr, DrainData} !== {exp_a[k], exp_d[k]}) begin
                    fails++;
                    $display("FAIL full_order%0d got=%h/%h exp=%h/%h", k,
                             DrainAddr, DrainData, exp_a[k], exp_d[k]);
                end
                k++;
            end
            tick();
        end
        #1;
        tests++;
        if ({k[2:0], Empty} !== {3'd4, 1'b1}) begin
            fails++;
            $display("FAIL full_drain got=%0d/%0b exp=4/1", k, Empty);
        end
        clr();
    endtask

    task automatic test_stable_flush();
        int pops;
        do_reset();
        store(32'h600, 32'hA0, 0);
        store(32'h604, 32'hA1, 0);
        store(32'h608, 32'hA2, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if ({DrainValid, DrainAddr, DrainData} !==
                {1'b1, 32'h600, 32'hA0}) begin
                fails++;
                $display("FAIL stable%0d got=%0b/%h/%h exp=1/600/a0", c,
                         DrainValid, DrainAddr, DrainData);
            end
            tick();
        end
        LoadValidM = 1; LoadAddrM = 32'h900;
        Flush = 1; DrainReady = 1;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (DrainValid && DrainReady) pops++;
            if (Empty) break;
            tick();
            Flush = 0;
        end
        tests++;
        if ({pops[2:0], Empty, DrainValid} !== {3'd3, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL flush got=%0d/%0b/%0b exp=3/1/0",
                     pops, Empty, DrainValid);
        end
        clr();
    endtask

    task automatic test_wrap_rst();
        logic [31:0] got [16];
        int n;
        do_reset();
        DrainReady = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            StoreValidM = 1;
            StoreAddrM  = 32'h700 + 32'(4 * i);
            StoreDataM  = 32'(i);
            #1;
            if (DrainValid && n < 16) begin
                got[n] = DrainAddr; n++;
            end
            if (i == 6) begin
                tests++;
                if (Count !== 3'd2) begin
                    fails++; $display("FAIL wrap_count got=%0d exp=2", Count);
                end
            end
            tick();
        end
        StoreValidM = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (DrainValid && n < 16) begin
                got[n] = DrainAddr; n++;
            end
            if (Empty && !DrainValid) break;
            tick();
        end
        tests++;
        if (n != 10) begin
            fails++; $display("FAIL wrap_n got=%0d exp=10", n);
        end
        for (int i = 0; i < 10 && i < n; i++) begin
            tests++;
            if (got[i] !== 32'h700 + 32'(4 * i)) begin
                fails++;
                $display("FAIL wrap_order%0d got=%h exp=%h", i, got[i],
                         32'h700 + 32'(4 * i));
            end
        end
        clr();
        store(32'h800, 32'h1, 0);
        store(32'h804, 32'h2, 0);
        tick();
        #1;
        tests++;
        if (DrainValid !== 1'b1) begin
            fails++; $display("FAIL mid_pre got=%0b exp=1", DrainValid);
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        tests++;
        if ({DrainValid, Count, Empty} !== {1'b0, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL mid_rst got=%0b/%0d/%0b exp=0/0/1",
                     DrainValid, Count, Empty);
        end
        clr();
    endtask

    initial begin
        clr();
        test_reset();
        test_fwd_word();
        test_fwd_byte();
        test_youngest();
        test_full();
        test_stable_flush();
        test_wrap_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
